// File: rtl/frame_upload_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : frame_upload_scheduler
// Description : Sequences a frame-buffer uploader against DSI vsync timing.
//               On each vsync it latches the active buffer base address and
//               frame size, enables the uploader two cycles later, counts FIFO
//               writes to detect frame completion, applies buffer swaps at
//               frame boundaries, and flags late vsyncs and read errors.
// Ports       : clk, rst            - clock, async active-high reset
//               ctrl_enable         - run (1) / force idle (0)
//               buf_addr_a/b        - frame buffer base addresses
//               frame_bytes         - size handed to the uploader
//               frame_words         - FIFO writes per frame (0 acts as 1)
//               swap_req, vsync     - single-cycle request / frame-start pulses
//               upl_fifo_write      - uploader FIFO write strobe
//               upl_read_error      - uploader read-error pulse
//               upl_enable, upl_base_address, upl_total_size - uploader control
//               buf_sel, swap_ack, frame_done, frame_cnt     - frame status
//               late_err, rd_err    - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module frame_upload_scheduler #(
    parameter int FRM_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_enable,
    input  logic [31:0]          buf_addr_a,
    input  logic [31:0]          buf_addr_b,
    input  logic [31:0]          frame_bytes,
    input  logic [31:0]          frame_words,
    input  logic                 swap_req,
    input  logic                 vsync,
    input  logic                 upl_fifo_write,
    input  logic                 upl_read_error,
    output logic                 upl_enable,
    output logic [31:0]          upl_base_address,
    output logic [31:0]          upl_total_size,
    output logic                 buf_sel,
    output logic                 swap_ack,
    output logic                 frame_done,
    output logic [FRM_CNT_W-1:0] frame_cnt,
    output logic                 late_err,
    output logic                 rd_err
);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_WAIT_VSYNC = 3'd1;
    localparam logic [2:0] c_LOAD       = 3'd2;
    localparam logic [2:0] c_RUN        = 3'd3;
    localparam logic [2:0] c_GAP        = 3'd4;
    localparam logic [2:0] c_ERROR      = 3'd5;

    logic [2:0]           r_state;
    logic                 r_upl_enable;
    logic [31:0]          r_base_address;
    logic [31:0]          r_total_size;
    logic                 r_buf_sel;
    logic                 r_swap_ack;
    logic                 r_frame_done;
    logic [FRM_CNT_W-1:0] r_frame_cnt;
    logic                 r_late_err;
    logic                 r_rd_err;
    logic                 r_swap_pend;
    logic [31:0]          r_word_cnt;

    logic [31:0] w_words_tgt;
    logic [31:0] w_word_next;
    logic        w_complete;
    logic        w_swap_pend;
    logic        w_next_sel;
    logic [31:0] w_cur_addr;
    logic [31:0] w_next_addr;

    // A zero word count would never complete; treat it as a single word.
    assign w_words_tgt = (frame_words == 32'd0) ? 32'd1 : frame_words;
    assign w_word_next = r_word_cnt + 32'd1;
    assign w_complete  = upl_fifo_write && (w_word_next == w_words_tgt);

    // A request arriving on the completing cycle still counts for this boundary.
    assign w_swap_pend = r_swap_pend | swap_req;
    assign w_next_sel  = r_buf_sel ^ w_swap_pend;
    assign w_cur_addr  = r_buf_sel  ? buf_addr_b : buf_addr_a;
    // Address for a frame that starts on the same cycle the previous one
    // completes: it must already reflect the swap applied at that boundary.
    assign w_next_addr = w_next_sel ? buf_addr_b : buf_addr_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_upl_enable   <= 1'b0;
            r_base_address <= 32'd0;
            r_total_size   <= 32'd0;
            r_buf_sel      <= 1'b0;
            r_swap_ack     <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_cnt    <= '0;
            r_late_err     <= 1'b0;
            r_rd_err       <= 1'b0;
            r_swap_pend    <= 1'b0;
            r_word_cnt     <= 32'd0;
        end else begin
            r_frame_done <= 1'b0;
            r_swap_ack   <= 1'b0;
            r_swap_pend  <= w_swap_pend;

            if (!ctrl_enable) begin
                r_state      <= c_IDLE;
                r_upl_enable <= 1'b0;
                // Errors stay visible until software has parked the block.
                if (r_state == c_IDLE) begin
                    r_late_err <= 1'b0;
                    r_rd_err   <= 1'b0;
                end
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_upl_enable <= 1'b0;
                        r_state      <= c_WAIT_VSYNC;
                    end

                    c_WAIT_VSYNC: begin
                        r_upl_enable <= 1'b0;
                        if (vsync) begin
                            r_base_address <= w_cur_addr;
                            r_total_size   <= frame_bytes;
                            r_word_cnt     <= 32'd0;
                            r_state        <= c_LOAD;
                        end
                    end

                    c_LOAD: begin
                        if (upl_read_error) begin
                            r_rd_err     <= 1'b1;
                            r_upl_enable <= 1'b0;
                            r_state      <= c_ERROR;
                        end else begin
                            r_upl_enable <= 1'b1;
                            r_state      <= c_RUN;
                        end
                    end

                    c_RUN: begin
                        if (upl_read_error) begin
                            r_rd_err     <= 1'b1;
                            r_upl_enable <= 1'b0;
                            r_state      <= c_ERROR;
                        end else if (w_complete) begin
                            r_upl_enable <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_frame_cnt  <= r_frame_cnt + 1'b1;
                            if (w_swap_pend) begin
                                r_buf_sel   <= ~r_buf_sel;
                                r_swap_ack  <= 1'b1;
                                r_swap_pend <= 1'b0;
                            end
                            if (vsync) begin
                                // Coincident vsync is the next frame start.
                                r_base_address <= w_next_addr;
                                r_total_size   <= frame_bytes;
                                r_word_cnt     <= 32'd0;
                                r_state        <= c_LOAD;
                            end else begin
                                r_word_cnt <= w_word_next;
                                r_state    <= c_WAIT_VSYNC;
                            end
                        end else if (vsync) begin
                            // Late vsync: relatch now so GAP can act as the
                            // load cycle, giving exactly one low enable cycle
                            // and a fresh rising edge for the uploader.
                            r_late_err     <= 1'b1;
                            r_upl_enable   <= 1'b0;
                            r_base_address <= w_cur_addr;
                            r_total_size   <= frame_bytes;
                            r_word_cnt     <= 32'd0;
                            r_state        <= c_GAP;
                        end else if (upl_fifo_write) begin
                            r_word_cnt <= w_word_next;
                        end
                    end

                    c_GAP: begin
                        if (upl_read_error) begin
                            r_rd_err     <= 1'b1;
                            r_upl_enable <= 1'b0;
                            r_state      <= c_ERROR;
                        end else begin
                            r_upl_enable <= 1'b1;
                            r_state      <= c_RUN;
                        end
                    end

                    c_ERROR: begin
                        r_upl_enable <= 1'b0;
                    end

                    default: begin
                        r_upl_enable <= 1'b0;
                        r_state      <= c_IDLE;
                    end
                endcase
            end
        end
    end

    assign upl_enable       = r_upl_enable;
    assign upl_base_address = r_base_address;
    assign upl_total_size   = r_total_size;
    assign buf_sel          = r_buf_sel;
    assign swap_ack         = r_swap_ack;
    assign frame_done       = r_frame_done;
    assign frame_cnt        = r_frame_cnt;
    assign late_err         = r_late_err;
    assign rd_err           = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_frame_upload_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_upload_scheduler
// Description : Randomized bench for frame_upload_scheduler. The driver keeps
//               a transaction-level model (active buffer, pending swap, frame
//               count, late flag) and queues the expected uploader-start and
//               frame-done events; a monitor pops and compares them when the
//               DUT presents them. A second instance uses FRM_CNT_W=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_upload_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_enable;
    logic [31:0] buf_addr_a;
    logic [31:0] buf_addr_b;
    logic [31:0] frame_bytes;
    logic [31:0] frame_words;
    logic        swap_req;
    logic        vsync;
    logic        upl_fifo_write;
    logic        upl_read_error;

    logic        upl_enable;
    logic [31:0] upl_base_address;
    logic [31:0] upl_total_size;
    logic        buf_sel;
    logic        swap_ack;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        late_err;
    logic        rd_err;

    logic        s_upl_enable;
    logic [31:0] s_upl_base_address;
    logic [31:0] s_upl_total_size;
    logic        s_buf_sel;
    logic        s_swap_ack;
    logic        s_frame_done;
    logic [1:0]  s_frame_cnt;
    logic        s_late_err;
    logic        s_rd_err;

    frame_upload_scheduler #(.FRM_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ctrl_enable(ctrl_enable),
        .buf_addr_a(buf_addr_a), .buf_addr_b(buf_addr_b),
        .frame_bytes(frame_bytes), .frame_words(frame_words),
        .swap_req(swap_req), .vsync(vsync),
        .upl_fifo_write(upl_fifo_write), .upl_read_error(upl_read_error),
        .upl_enable(upl_enable), .upl_base_address(upl_base_address),
        .upl_total_size(upl_total_size), .buf_sel(buf_sel),
        .swap_ack(swap_ack), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .late_err(late_err), .rd_err(rd_err)
    );

    frame_upload_scheduler #(.FRM_CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .ctrl_enable(ctrl_enable),
        .buf_addr_a(buf_addr_a), .buf_addr_b(buf_addr_b),
        .frame_bytes(frame_bytes), .frame_words(frame_words),
        .swap_req(swap_req), .vsync(vsync),
        .upl_fifo_write(upl_fifo_write), .upl_read_error(upl_read_error),
        .upl_enable(s_upl_enable), .upl_base_address(s_upl_base_address),
        .upl_total_size(s_upl_total_size), .buf_sel(s_buf_sel),
        .swap_ack(s_swap_ack), .frame_done(s_frame_done), .frame_cnt(s_frame_cnt),
        .late_err(s_late_err), .rd_err(s_rd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [31:0] base; logic [31:0] size; } rise_t;
    typedef struct { int cyc; int cnt; logic sel; logic ack; } done_t;

    rise_t q_rise[$];
    done_t q_done[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_sel   = 1'b0;
    bit m_pend  = 1'b0;
    bit m_late  = 1'b0;
    int m_cnt   = 0;
    bit started = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Uploader enable is expected to rise two cycles after the driving cycle.
    task automatic push_rise();
        rise_t r;
        r.cyc  = cyc + 2;
        r.base = m_sel ? buf_addr_b : buf_addr_a;
        r.size = frame_bytes;
        q_rise.push_back(r);
    endtask

    task automatic complete_model();
        done_t d;
        m_cnt++;
        d.ack = m_pend;
        if (m_pend) m_sel = ~m_sel;
        m_pend = 1'b0;
        d.cyc  = cyc + 1;
        d.cnt  = m_cnt;
        d.sel  = m_sel;
        q_done.push_back(d);
    endtask

    task automatic writes(input int n, input bit completes, input bit coinc, input bit may_swap);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                if (may_swap && $urandom_range(0, 9) == 0) begin swap_req = 1'b1; m_pend = 1'b1; end
                tick();
                swap_req = 1'b0;
            end
            upl_fifo_write = 1'b1;
            if (may_swap && $urandom_range(0, 5) == 0) begin swap_req = 1'b1; m_pend = 1'b1; end
            if (completes && i == n - 1) begin
                complete_model();
                if (coinc) begin vsync = 1'b1; push_rise(); end
            end
            tick();
            upl_fifo_write = 1'b0;
            swap_req       = 1'b0;
            vsync          = 1'b0;
        end
    endtask

    // vsync followed by the load cycle; the write offered then must be ignored.
    task automatic start_frame(input bit late);
        vsync = 1'b1;
        if (late) m_late = 1'b1;
        push_rise();
        tick();
        vsync = 1'b0;
        upl_fifo_write = 1'($urandom_range(0, 1));
        tick();
        upl_fifo_write = 1'b0;
    endtask

    // late_mode/coinc_mode: 0 never, 1 forced, 2 random
    task automatic run_frame(input bit force_swap, input int late_mode, input int coinc_mode);
        int  t;
        int  k;
        bit  coinc;
        if (!started) start_frame(1'b0);
        t = (frame_words == 32'd0) ? 1 : int'(frame_words);
        if (force_swap) begin
            writes(2, 1'b0, 1'b0, 1'b0);
            swap_req = 1'b1; m_pend = 1'b1;
            tick();
            swap_req = 1'b0;
            t = t - 2;
            writes(t, 1'b1, 1'b0, 1'b0);
            coinc = 1'b0;
        end else begin
            if (t >= 2 && (late_mode == 1 || (late_mode == 2 && $urandom_range(0, 3) == 0))) begin
                k = (late_mode == 1) ? 3 : $urandom_range(1, t - 1);
                writes(k, 1'b0, 1'b0, late_mode == 2);
                start_frame(1'b1);
            end
            coinc = (coinc_mode == 1) || (coinc_mode == 2 && $urandom_range(0, 3) == 0);
            writes(t, 1'b1, coinc, coinc_mode == 2);
        end
        if (coinc) begin
            upl_fifo_write = 1'($urandom_range(0, 1));
            tick();
            upl_fifo_write = 1'b0;
            started = 1'b1;
        end else begin
            for (int e = 0; e < int'($urandom_range(0, 2)); e++) begin
                upl_fifo_write = 1'b1;
                tick();
                upl_fifo_write = 1'b0;
            end
            if (coinc_mode == 2 && $urandom_range(0, 4) == 0) begin swap_req = 1'b1; m_pend = 1'b1; end
            tick();
            swap_req = 1'b0;
            started = 1'b0;
        end
        chk("late_err", late_err, m_late);
        chk("rd_err", rd_err, 0);
    endtask

    // Monitor: compares DUT-presented events against the queued expectations.
    logic  prev_en = 1'b0;
    rise_t mr;
    done_t md;
    always @(negedge clk) begin
        if (!rst) begin
            if (upl_enable && !prev_en) begin
                if (q_rise.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rise_unexpected: got upl_enable rise at cycle %0d expected none", cyc);
                end else begin
                    mr = q_rise.pop_front();
                    chk("rise_cycle", 64'(cyc), 64'(mr.cyc));
                    chk("upl_base_address", upl_base_address, mr.base);
                    chk("upl_total_size", upl_total_size, mr.size);
                end
            end
            if (frame_done) begin
                if (q_done.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: got frame_done at cycle %0d expected none", cyc);
                end else begin
                    md = q_done.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(md.cyc));
                    chk("frame_cnt", frame_cnt, 64'(md.cnt & 16'hFFFF));
                    chk("frame_cnt_w2", s_frame_cnt, 64'(md.cnt & 3));
                    chk("buf_sel", buf_sel, md.sel);
                    chk("swap_ack", swap_ack, md.ack);
                end
            end
            if (swap_ack && !frame_done) begin
                checks++; errors++;
                $display("FAIL swap_ack_alone: got swap_ack=1 frame_done=0 expected both");
            end
        end
        prev_en = upl_enable;
    end

    initial begin
        #300000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ctrl_enable = 1'b0;
        buf_addr_a = 32'h1000; buf_addr_b = 32'h8000;
        frame_bytes = 32'h0000_0600; frame_words = 32'd6;
        swap_req = 1'b0; vsync = 1'b0; upl_fifo_write = 1'b0; upl_read_error = 1'b0;
        repeat (3) tick();
        chk("rst_upl_enable", upl_enable, 0);
        chk("rst_base", upl_base_address, 0);
        chk("rst_size", upl_total_size, 0);
        chk("rst_buf_sel", buf_sel, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_swap_ack", swap_ack, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_late_err", late_err, 0);
        chk("rst_rd_err", rd_err, 0);
        rst = 1'b0; ctrl_enable = 1'b1;
        tick(); tick();

        // Directed frames: plain, swap, late vsync, coincident vsync.
        run_frame(1'b0, 0, 0);
        run_frame(1'b1, 0, 0);
        run_frame(1'b0, 1, 0);
        chk("late_after_late", late_err, 1);
        run_frame(1'b0, 0, 1);
        run_frame(1'b0, 0, 0);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            if (!started) begin
                buf_addr_a  = $urandom & 32'hFFFF_FFF0;
                buf_addr_b  = $urandom & 32'hFFFF_FFF0;
                frame_bytes = $urandom_range(1, 4096);
                frame_words = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 8));
            end
            run_frame(1'b0, 2, (f == 39) ? 0 : 2);
        end

        // Read error during RUN, ERROR hold, then release through IDLE.
        frame_words = 32'd6;
        start_frame(1'b0);
        writes(2, 1'b0, 1'b0, 1'b0);
        upl_read_error = 1'b1;
        tick();
        upl_read_error = 1'b0;
        chk("err_upl_enable", upl_enable, 0);
        chk("err_rd_err", rd_err, 1);
        vsync = 1'b1; swap_req = 1'b1; m_pend = 1'b1;
        tick();
        vsync = 1'b0; swap_req = 1'b0;
        for (int w = 0; w < 4; w++) begin upl_fifo_write = 1'b1; tick(); end
        upl_fifo_write = 1'b0;
        tick();
        chk("err_hold_enable", upl_enable, 0);
        chk("err_hold_rd_err", rd_err, 1);
        chk("err_frame_cnt", frame_cnt, 64'(m_cnt & 16'hFFFF));
        ctrl_enable = 1'b0;
        tick(); tick();
        m_late = 1'b0;
        chk("idle_rd_err_clr", rd_err, 0);
        chk("idle_late_err_clr", late_err, 0);
        chk("idle_upl_enable", upl_enable, 0);
        ctrl_enable = 1'b1;
        tick(); tick();
        run_frame(1'b0, 0, 0);

        // Asynchronous reset while the uploader is running.
        buf_sel_prep: begin
            frame_words = 32'd6;
            start_frame(1'b0);
            writes(2, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        #2;
        chk("pre_rst_enable", upl_enable, 1);
        rst = 1'b1;
        #1;
        chk("arst_upl_enable", upl_enable, 0);
        chk("arst_frame_cnt", frame_cnt, 0);
        chk("arst_frame_cnt_w2", s_frame_cnt, 0);
        chk("arst_buf_sel", buf_sel, 0);
        chk("arst_base", upl_base_address, 0);
        chk("arst_size", upl_total_size, 0);
        chk("arst_flags", {late_err, rd_err, frame_done, swap_ack}, 0);
        m_sel = 1'b0; m_pend = 1'b0; m_late = 1'b0; m_cnt = 0; started = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        tick(); tick();
        run_frame(1'b0, 0, 0);

        repeat (5) tick();
        chk("rise_queue_empty", 64'(q_rise.size()), 0);
        chk("done_queue_empty", 64'(q_done.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_upload_scheduler.md
FRAME_UPLOAD_SCHEDULER -- requirements
Module: frame_upload_scheduler

Interface
REQ-001 Parameter: FRM_CNT_W, default 16, width of the frame counter.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 ctrl_enable  in  1  level; 1 runs the scheduler, 0 forces IDLE.
REQ-005 buf_addr_a  in  32  base address of frame buffer A.
REQ-006 buf_addr_b  in  32  base address of frame buffer B.
REQ-007 frame_bytes  in  32  frame size in address units, passed to the uploader.
REQ-008 frame_words  in  32  expected 32-bit FIFO writes per frame; 0 is illegal (treated as 1).
REQ-009 swap_req  in  1  one-cycle pulse requesting a buffer swap at the next frame boundary.
REQ-010 vsync  in  1  one-cycle frame-start pulse from DSI timing.
REQ-011 upl_fifo_write  in  1  pixel FIFO write strobe from the uploader.
REQ-012 upl_read_error  in  1  uploader read-error pulse.
REQ-013 upl_enable  out  1  uploader enable.
REQ-014 upl_base_address  out  32  uploader base address, stable while upl_enable=1.
REQ-015 upl_total_size  out  32  uploader total size, stable while upl_enable=1.
REQ-016 buf_sel  out  1  active buffer, 0=A, 1=B.
REQ-017 swap_ack  out  1  one-cycle pulse when a pending swap is applied.
REQ-018 frame_done  out  1  one-cycle pulse when frame_words writes are counted.
REQ-019 frame_cnt  out  FRM_CNT_W  completed frames, wraps to 0.
REQ-020 late_err  out  1  sticky; vsync arrived before frame completion.
REQ-021 rd_err  out  1  sticky; uploader reported a read error.

Function
REQ-022 States SHALL be IDLE, WAIT_VSYNC, LOAD, RUN, GAP, ERROR; every output SHALL be registered.
REQ-023 IDLE: upl_enable=0. ctrl_enable=1 -> WAIT_VSYNC.
REQ-024 WAIT_VSYNC: vsync -> LOAD. On that cycle, latch the buffer address chosen by buf_sel into upl_base_address and frame_bytes into upl_total_size, and clear the word counter.
REQ-025 LOAD: one cycle, upl_enable still 0; upl_enable rises on the cycle that enters RUN, 2 cycles after vsync.
REQ-026 RUN: upl_enable=1. Each upl_fifo_write increments the 32-bit word counter.
REQ-027 When a write brings the counter to frame_words, SHALL drop upl_enable, pulse frame_done, increment frame_cnt and enter WAIT_VSYNC, all on the next cycle.
REQ-028 Writes after completion or outside RUN are ignored.
REQ-029 vsync in RUN before completion SHALL set late_err and enter GAP (upl_enable=0 for exactly one cycle); frame_done and frame_cnt are not updated. GAP then behaves as the WAIT_VSYNC-on-vsync path: relatch, then LOAD, then RUN. This guarantees the uploader sees an enable rising edge and restarts from base.
REQ-030 vsync coincident with the completing write: completion takes priority and the vsync is consumed as the next frame start (WAIT_VSYNC -> LOAD directly); late_err is not set.
REQ-031 swap_req sets a pending flag. At each frame_done, a pending swap toggles buf_sel, pulses swap_ack with frame_done, and clears the flag.
REQ-032 swap_req coincident with frame_done applies at that boundary; repeated requests before a boundary collapse into one.
REQ-033 upl_read_error in LOAD, RUN or GAP SHALL set rd_err, drop upl_enable next cycle and enter ERROR; ERROR holds upl_enable=0 until ctrl_enable=0.
REQ-034 ctrl_enable=0 in any state SHALL drop upl_enable and enter IDLE next cycle; pending swap is retained.
REQ-035 late_err and rd_err SHALL clear only in IDLE with ctrl_enable=0, or on reset.
REQ-036 frame_cnt SHALL wrap from 2^FRM_CNT_W-1 to 0.

Reset
REQ-037 rst SHALL asynchronously force: state IDLE; upl_enable, swap_ack, frame_done, late_err, rd_err, buf_sel, pending swap = 0; upl_base_address, upl_total_size, frame_cnt, word counter = 0.
REQ-038 rst asserted mid-RUN SHALL drop upl_enable immediately; after release, operation restarts from IDLE.

Verification
REQ-039 Normal frame: A=0x1000, frame_words=6, vsync, 6 writes -> upl_enable high 2 cycles after vsync; upl_base_address=0x1000; after the 6th write, frame_done pulse, frame_cnt=1, upl_enable=0.
REQ-040 Swap: swap_req mid-frame, B=0x8000 -> swap_ack with frame_done, buf_sel=1, next frame upl_base_address=0x8000.
REQ-041 Late vsync: vsync after 3 of 6 writes -> late_err=1, upl_enable low exactly 1 cycle then high, frame_cnt unchanged.
REQ-042 Read error in RUN -> rd_err=1, upl_enable=0, ERROR held; ctrl_enable=0 -> IDLE, flags cleared.
REQ-043 Coincident vsync and 6th write -> frame_done, late_err=0, next frame LOAD immediately.
REQ-044 FRM_CNT_W=2, 5 frames -> frame_cnt sequence 1,2,3,0,1; async rst mid-RUN -> all outputs 0 without a clock edge.
